counter_monitor_16: RTL
=======================

COUNTER_MONITOR_16 -- requirements
Module: counter_monitor_16

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port ENB, input, 1 bit: counter enable, the same net that drives the 16-bit counter.
REQ-004 The block SHALL have port MODO, input, 2 bits: counter mode, the same net that drives the counter.
REQ-005 The block SHALL have port D, input, 16 bits: counter parallel-load data, the same net that drives the counter.
REQ-006 The block SHALL have port Q, input, 16 bits: counter output under observation.
REQ-007 The block SHALL have port RCO, input, 1 bit: counter ripple-carry output under observation.
REQ-008 The block SHALL have port ERR, output, 1 bit: sticky mismatch flag.
REQ-009 The block SHALL have port ERR_CNT, output, 8 bits: mismatch count, saturating.
REQ-010 The block SHALL have port CHK_CNT, output, 16 bits: number of comparisons performed, saturating.
REQ-011 The block SHALL have port RCO_CNT, output, 8 bits: number of cycles with RCO sampled high, saturating.
REQ-012 The block SHALL have port STATE, output, 2 bits: current FSM state; IDLE=00, CHECK=01, FAULT=10; 11 is unused.

Function
REQ-013 Every rising edge SHALL sample ENB, MODO, D and Q into a one-deep history register: hENB, hMODO, hD, hQ.
REQ-014 The expected next value E SHALL be computed from history modulo 2^16 as follows:
- hENB=0: E=hQ.
- hMODO=00: E=hQ+1.
- hMODO=01: E=hQ-1.
- hMODO=10: E=hQ-3.
- hMODO=11: E=hD.
REQ-015 Wrap-around SHALL follow mod 2^16 arithmetic: FFFF+1=0000; 0000-1=FFFF; 0001-3=FFFE; 0002-3=FFFF.
REQ-016 The FSM in IDLE SHALL perform no comparison; it SHALL go to CHECK on the first edge with ENB=1 and MODO=11, and the history is captured on that same edge.
REQ-017 In CHECK and FAULT, each edge SHALL compare Q with E and increment CHK_CNT, saturating at FFFF.
REQ-018 On a mismatch, ERR_CNT SHALL increment (saturating at FF), ERR SHALL be set, and CHECK SHALL go to FAULT; all take effect on the same edge.
REQ-019 FAULT SHALL continue comparing and counting, and SHALL be left only via RESET.
REQ-020 After every comparison, history SHALL be reloaded from the current inputs, so the next check is relative to the actual Q, not the predicted Q.
REQ-021 RCO_CNT SHALL increment on every edge where RCO=1, in any state, saturating at FF.
REQ-022 Outputs SHALL be registered only, with a one-cycle latency from the compared edge to ERR/ERR_CNT/CHK_CNT updates.
REQ-023 ENB=0 with MODO=11 SHALL mean hold, not load.
REQ-024 A load (hMODO=11, hENB=1) seen while in CHECK SHALL be checked like any other mode.

Reset
REQ-025 RESET=1 at a rising edge SHALL force STATE=IDLE, ERR=0, ERR_CNT=00, CHK_CNT=0000, RCO_CNT=00, and clear the history to 0.
REQ-026 RESET SHALL dominate every other event on the same edge, including a mismatch, an RCO pulse, and the IDLE->CHECK trigger.
REQ-027 A RESET asserted mid-CHECK or mid-FAULT SHALL discard the history; checking resumes only after a new load per REQ-016.
REQ-028 There SHALL be no asynchronous reset path; outputs are undefined before the first RESET edge.

Verification
REQ-029 Up-count wrap: load D=FFFD, then MODO=00 for 4 cycles with Q following FFFE, FFFF, 0000, 0001 -> ERR=0, CHK_CNT=0004, STATE=01.
REQ-030 Down-by-3 wrap: load D=0004, then MODO=10 with Q following 0001, FFFE, FFFB -> ERR=0, CHK_CNT=0003.
REQ-031 Injected fault: load D=0000, MODO=00, with Q following 0001, then 0003 -> ERR=1 and STATE=10 one cycle after the bad sample, ERR_CNT=01; a further correct step gives ERR_CNT=01 and CHK_CNT still incrementing.
REQ-032 Hold and disabled load: ENB=0 with MODO=11, D=1234 for 3 cycles and Q constant at 00AA -> no mismatch, STATE unchanged (stays IDLE if not yet armed).
REQ-033 Saturation: 300 consecutive mismatches -> ERR_CNT=FF; 300 RCO-high cycles -> RCO_CNT=FF.
REQ-034 Reset mid-FAULT: RESET for 1 cycle -> all outputs zero and STATE=00; random Q afterwards without a load -> ERR stays 0 and CHK_CNT=0000.

Source files
------------

// File: rtl/counter_monitor_16.sv
// Scoreboard for a 16-bit up/down/load counter: it predicts the next Q from
// the previous edge's inputs and counts checks, mismatches and RCO-high cycles.
module counter_monitor_16 (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENB,
    input  logic [1:0]  MODO,
    input  logic [15:0] D,
    input  logic [15:0] Q,
    input  logic        RCO,
    output logic        ERR,
    output logic [7:0]  ERR_CNT,
    output logic [15:0] CHK_CNT,
    output logic [7:0]  RCO_CNT,
    output logic [1:0]  STATE
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t      state;
    logic        h_enb;
    logic [1:0]  h_modo;
    logic [15:0] h_d;
    logic [15:0] h_q;
    logic [15:0] expected;
    logic        mismatch;

    // Prediction is relative to the Q actually seen last edge, so one glitch
    // is reported once rather than on every following cycle.
    always_comb begin
        expected = h_q;
        if (h_enb) begin
            case (h_modo)
                2'b00:   expected = h_q + 16'd1;
                2'b01:   expected = h_q - 16'd1;
                2'b10:   expected = h_q - 16'd3;
                default: expected = h_d;
            endcase
        end
        mismatch = (Q != expected);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            ERR     <= 1'b0;
            ERR_CNT <= 8'h00;
            CHK_CNT <= 16'h0000;
            RCO_CNT <= 8'h00;
            h_enb   <= 1'b0;
            h_modo  <= 2'b00;
            h_d     <= 16'h0000;
            h_q     <= 16'h0000;
        end else begin
            h_enb  <= ENB;
            h_modo <= MODO;
            h_d    <= D;
            h_q    <= Q;
            if (RCO && RCO_CNT != 8'hFF)
                RCO_CNT <= RCO_CNT + 8'd1;
            case (state)
                IDLE: begin
                    // Arm on an enabled load: only then is Q known to follow D.
                    if (ENB && MODO == 2'b11)
                        state <= CHECK;
                end
                CHECK, FAULT: begin
                    if (CHK_CNT != 16'hFFFF)
                        CHK_CNT <= CHK_CNT + 16'd1;
                    if (mismatch) begin
                        ERR   <= 1'b1;
                        state <= FAULT;
                        if (ERR_CNT != 8'hFF)
                            ERR_CNT <= ERR_CNT + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign STATE = state;

endmodule
